// File: rtl/fpau_pkg.sv
// Shared FPAU definitions: special-value encodings, exponent bias and the
// sequencer state encoding used by the FP32 divider.
package fpau_pkg;

    localparam logic [31:0]        FP_NAN     = 32'h7FFF_FFFF;
    localparam logic [30:0]        FP_INF_MAG = 31'h7F80_0000;
    localparam logic [31:0]        FP_ZERO    = 32'h0000_0000;
    localparam logic signed [9:0]  FP_BIAS    = 10'sd127;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DIV   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } fpState_e;

    function automatic logic [31:0] fpInf(input logic sign);
        return {sign, FP_INF_MAG};
    endfunction

endpackage

// File: rtl/fpdiv32_seq_if.sv
// Start/busy/done handshake bundle of the sequential FP32 divider.
interface fpdiv32_seq_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] S;

    modport master (output start, A, B, input busy, done, S);
    modport slave  (input start, A, B, output busy, done, S);
endinterface

// File: rtl/checkspecial.sv
// Operand classifier shared with the multiplier; denormals read as zero.
module checkspecial
    import fpau_pkg::*;
(
    input  logic [30:0] mag,
    output logic        flagInf,
    output logic        flagNaN,
    output logic        flagZero
);

    assign flagInf  = (mag == FP_INF_MAG);
    assign flagNaN  = (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
    assign flagZero = (mag[30:23] == 8'h00);

endmodule

// File: rtl/fpdiv32_seq.sv
// Sequential FP32 divider S = A / B, restoring radix-2, one quotient bit per clock.
// Optional macro FPDIV_RNE_EN selects round-to-nearest-even; otherwise truncate.
module fpdiv32_seq
    import fpau_pkg::*;
#(
    parameter logic [31:0] NAN_PATTERN = FP_NAN,
    parameter int          QBITS       = 26
) (
    input  logic         clk,
    input  logic         rst,
    fpdiv32_seq_if.slave bus
);

    fpState_e          stateR, stateNextS;
    logic [31:0]       aR, bR, sR;
    logic [24:0]       remR;
    logic [23:0]       mbR;
    logic [QBITS-1:0]  qR;
    logic [4:0]        cntR;
    logic signed [9:0] expR;
    logic              signR, doneR, busyR;

    logic              aInfS, aNaNS, aZeroS, bInfS, bNaNS, bZeroS;
    logic              acceptS, specialS, signS, incS;
    logic [31:0]       specialResS, roundResS;
    logic [22:0]       mantS;
    logic [23:0]       roundedS;
    logic signed [9:0] expNormS, expFinS;
`ifdef FPDIV_RNE_EN
    logic              guardS, stickyS;
`endif

    checkspecial uChkA (.mag(aR[30:0]), .flagInf(aInfS), .flagNaN(aNaNS), .flagZero(aZeroS));
    checkspecial uChkB (.mag(bR[30:0]), .flagInf(bInfS), .flagNaN(bNaNS), .flagZero(bZeroS));

    // busy also covers the done cycle, so a start there is ignored
    assign acceptS  = bus.start && !busyR && (stateR == IDLE);
    assign signS    = aR[31] ^ bR[31];
    assign bus.busy = busyR;
    assign bus.done = doneR;
    assign bus.S    = sR;

    // Special-operand classification, first match wins
    always_comb begin
        specialS    = 1'b1;
        specialResS = NAN_PATTERN;
        if (aNaNS || bNaNS)            specialResS = NAN_PATTERN;
        else if (aInfS && bInfS)       specialResS = NAN_PATTERN;
        else if (aZeroS && bZeroS)     specialResS = NAN_PATTERN;
        else if (aInfS)                specialResS = fpInf(signS);
        else if (bZeroS)               specialResS = fpInf(signS);
        else if (aZeroS)               specialResS = FP_ZERO;
        else if (bInfS)                specialResS = FP_ZERO;
        else begin
            specialS    = 1'b0;
            specialResS = FP_ZERO;
        end
    end

    // Normalise, round and range-check the finished quotient
    always_comb begin
        mantS    = qR[QBITS-3:1];
        expNormS = expR - 10'sd1;
`ifdef FPDIV_RNE_EN
        guardS   = qR[0];
        stickyS  = (remR != 25'd0);
`endif
        if (qR[QBITS-1]) begin
            mantS    = qR[QBITS-2:2];
            expNormS = expR;
`ifdef FPDIV_RNE_EN
            guardS   = qR[1];
            stickyS  = qR[0] | (remR != 25'd0);
`endif
        end else begin
            mantS    = qR[QBITS-3:1];
            expNormS = expR - 10'sd1;
`ifdef FPDIV_RNE_EN
            guardS   = qR[0];
            stickyS  = (remR != 25'd0);
`endif
        end
`ifdef FPDIV_RNE_EN
        incS = guardS & (stickyS | mantS[0]);
`else
        incS = 1'b0;
`endif
        roundedS = {1'b0, mantS} + {23'd0, incS};
        // a carry out leaves the fraction at zero and bumps the exponent
        if (roundedS[23]) expFinS = expNormS + 10'sd1;
        else              expFinS = expNormS;
        if (expFinS >= 10'sd255)    roundResS = fpInf(signR);
        else if (expFinS <= 10'sd0) roundResS = FP_ZERO;
        else                        roundResS = {signR, expFinS[7:0], roundedS[22:0]};
    end

    // Next-state logic
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            IDLE:    if (acceptS) stateNextS = CHECK; else stateNextS = IDLE;
            CHECK:   if (specialS) stateNextS = DONE; else stateNextS = DIV;
            DIV:     if (cntR == 5'(QBITS - 1)) stateNextS = ROUND; else stateNextS = DIV;
            ROUND:   stateNextS = DONE;
            DONE:    stateNextS = IDLE;
            default: stateNextS = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) stateR <= IDLE;
        else     stateR <= stateNextS;
    end

    // Operand latch, divider datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            aR    <= 32'd0;
            bR    <= 32'd0;
            sR    <= FP_ZERO;
            remR  <= 25'd0;
            mbR   <= 24'd0;
            qR    <= '0;
            cntR  <= 5'd0;
            expR  <= 10'sd0;
            signR <= 1'b0;
            doneR <= 1'b0;
            busyR <= 1'b0;
        end else begin
            doneR <= (stateR == DONE);
            if (acceptS)    busyR <= 1'b1;
            else if (doneR) busyR <= 1'b0;
            else            busyR <= busyR;
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        aR <= bus.A;
                        bR <= bus.B;
                    end
                end
                CHECK: begin
                    if (specialS) begin
                        sR <= specialResS;
                    end else begin
                        remR  <= {2'b01, aR[22:0]};
                        mbR   <= {1'b1, bR[22:0]};
                        qR    <= '0;
                        cntR  <= 5'd0;
                        expR  <= $signed({2'b00, aR[30:23]}) - $signed({2'b00, bR[30:23]}) + FP_BIAS;
                        signR <= signS;
                    end
                end
                DIV: begin
                    if (remR >= {1'b0, mbR}) begin
                        remR <= (remR - {1'b0, mbR}) << 1;
                        qR   <= {qR[QBITS-2:0], 1'b1};
                    end else begin
                        remR <= remR << 1;
                        qR   <= {qR[QBITS-2:0], 1'b0};
                    end
                    cntR <= cntR + 5'd1;
                end
                ROUND:   sR <= roundResS;
                default: ;
            endcase
        end
    end

endmodule
